// File: rtl/adc_cfg_sequencer_pkg.sv
// Shared constants for the AD9252 configuration sequencer:
// FSM encodings, register addresses and SPI words.
package adc_cfg_pkg;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_PWR_DLY    = 4'd1;
    localparam logic [3:0] S_ISSUE      = 4'd2;
    localparam logic [3:0] S_WAIT_ACK   = 4'd3;
    localparam logic [3:0] S_WAIT_IDLE  = 4'd4;
    localparam logic [3:0] S_GAP        = 4'd5;
    localparam logic [3:0] S_ALIGN_WAIT = 4'd6;
    localparam logic [3:0] S_DONE       = 4'd7;
    localparam logic [3:0] S_ERROR      = 4'd8;

    typedef enum logic {PH_TEST = 1'b0, PH_WORK = 1'b1} phase_t;

    localparam logic [7:0] REG_TEST_IO = 8'h0D;
    localparam logic [7:0] REG_XFER    = 8'hFF;

    localparam logic [31:0] TEST_WORD   = {8'h00, REG_TEST_IO, 16'h0C0C};
    localparam logic [31:0] WORK_WORD   = {8'h00, REG_TEST_IO, 16'h0000};
    localparam logic [31:0] UPDATE_WORD = {8'h00, REG_XFER, 16'h0101};

    // Step 0 carries the mode word, step 1 commits it with the transfer register.
    function automatic logic [31:0] cfg_word(phase_t ph, logic step);
        if (step)
            return UPDATE_WORD;
        return (ph == PH_WORK) ? WORK_WORD : TEST_WORD;
    endfunction

endpackage

// File: rtl/adc_cfg_sequencer_if.sv
// SPI master link: word, chip select and launch strobe
// from the sequencer, busy status back from the SPI master.
interface adc_cfg_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int CS_W   = 1
);
    logic [DATA_W-1:0] adc_data;
    logic [CS_W-1:0]   cs_sel;
    logic              start;
    logic              spi_busy;

    modport master (output adc_data, cs_sel, start, input spi_busy);
    modport slave  (input adc_data, cs_sel, start, output spi_busy);
endinterface

// File: rtl/adc_cfg_sequencer_dly_counter.sv
// Loadable down-counter shared by every timed FSM state.
// Stops at 1 (no wrap); a load of 0 behaves as 1.
module dly_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] cnt;

    // Reload on state entry, otherwise count down and park at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= (value == '0) ? W'(1) : value;
        else if (cnt > W'(1))
            cnt <= cnt - W'(1);
    end

    assign expire = (cnt == W'(1));
endmodule

// File: rtl/adc_cfg_sequencer.sv
// AD9252 multi-channel configuration sequencer: test pattern,
// alignment wait with retries, then work mode on every ADC.
module adc_cfg_sequencer
    import adc_cfg_pkg::*;
#(
    parameter int             N_CH      = 2,
    parameter int             DATA_W    = 32,
    parameter int             DLY_W     = 24,
    parameter logic [DLY_W-1:0] DELAY_CYC = 'h400,
    parameter logic [DLY_W-1:0] ALIGN_TO  = 'hFFFFFF,
    parameter int             MAX_RETRY = 3,
    parameter int             ACK_TO    = 16
) (
    input  logic                clk,
    input  logic                reset,
    adc_cfg_sequencer_if.master spi,
    input  logic [N_CH-1:0]     data_aligned,
    input  logic                recfg,
    output logic                test_cfg_done,
    output logic                spi_done,
    output logic                cfg_error,
    output logic [3:0]          retry_cnt,
    output logic [3:0]          state_o
);
    localparam int CS_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [3:0]       state, nxt;
    phase_t           ph, ph_n;
    logic [CS_W-1:0]  ch, ch_n;
    logic             step, step_n;
    logic             tcd_n, done_n, err_n;
    logic [3:0]       rty_n;
    logic             ld, expire;
    logic [DLY_W-1:0] ld_val;
    logic             start_q;
    logic [DATA_W-1:0] data_q;
    logic [CS_W-1:0]  cs_q;
    logic             last_ch;

    assign last_ch = (ch == CS_W'(N_CH - 1));

    dly_counter #(.W(DLY_W)) u_dly (
        .clk    (clk),
        .reset  (reset),
        .load   (ld),
        .value  (ld_val),
        .expire (expire)
    );

    // Next state, sequencer position, flags and counter reloads.
    always_comb begin
        nxt    = state;
        ph_n   = ph;
        ch_n   = ch;
        step_n = step;
        tcd_n  = test_cfg_done;
        done_n = spi_done;
        err_n  = cfg_error;
        rty_n  = retry_cnt;
        ld     = 1'b0;
        ld_val = DELAY_CYC;
        case (state)
            S_IDLE: if (!spi.spi_busy) begin
                nxt = S_PWR_DLY;
                ld  = 1'b1;
            end
            S_PWR_DLY: if (expire)
                nxt = S_ISSUE;
            S_ISSUE: begin
                nxt    = S_WAIT_ACK;
                ld     = 1'b1;
                ld_val = DLY_W'(ACK_TO);
            end
            S_WAIT_ACK: if (spi.spi_busy || expire)
                nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!spi.spi_busy) begin
                nxt = S_GAP;
                ld  = 1'b1;
            end
            S_GAP: if (expire) begin
                if (!step) begin
                    step_n = 1'b1;
                    nxt    = S_ISSUE;
                end else if (!last_ch) begin
                    ch_n   = ch + CS_W'(1);
                    step_n = 1'b0;
                    nxt    = S_ISSUE;
                end else if (ph == PH_TEST) begin
                    nxt    = S_ALIGN_WAIT;
                    tcd_n  = 1'b1;
                    ld     = 1'b1;
                    ld_val = ALIGN_TO;
                end else begin
                    nxt    = S_DONE;
                    done_n = 1'b1;
                end
            end
            S_ALIGN_WAIT: begin
                if (&data_aligned) begin
                    ph_n   = PH_WORK;
                    ch_n   = '0;
                    step_n = 1'b0;
                    nxt    = S_ISSUE;
                end else if (expire) begin
                    if (retry_cnt < 4'(MAX_RETRY)) begin
                        rty_n  = retry_cnt + 4'd1;
                        tcd_n  = 1'b0;
                        ch_n   = '0;
                        step_n = 1'b0;
                        nxt    = S_ISSUE;
                    end else begin
                        tcd_n = 1'b0;
                        err_n = 1'b1;
                        nxt   = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: if (recfg) begin
                nxt    = S_IDLE;
                ph_n   = PH_TEST;
                ch_n   = '0;
                step_n = 1'b0;
                tcd_n  = 1'b0;
                done_n = 1'b0;
                err_n  = 1'b0;
                rty_n  = 4'd0;
            end
            default: begin
                nxt    = S_IDLE;
                ph_n   = PH_TEST;
                ch_n   = '0;
                step_n = 1'b0;
            end
        endcase
    end

    // Registered state and outputs; the SPI word is latched as ISSUE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            ph            <= PH_TEST;
            ch            <= '0;
            step          <= 1'b0;
            test_cfg_done <= 1'b0;
            spi_done      <= 1'b0;
            cfg_error     <= 1'b0;
            retry_cnt     <= 4'd0;
            start_q       <= 1'b0;
            data_q        <= '0;
            cs_q          <= '0;
        end else begin
            state         <= nxt;
            ph            <= ph_n;
            ch            <= ch_n;
            step          <= step_n;
            test_cfg_done <= tcd_n;
            spi_done      <= done_n;
            cfg_error     <= err_n;
            retry_cnt     <= rty_n;
            start_q       <= (nxt == S_ISSUE);
            if (nxt == S_ISSUE) begin
                data_q <= DATA_W'(cfg_word(ph_n, step_n));
                cs_q   <= ch_n;
            end
        end
    end

    assign spi.start    = start_q;
    assign spi.adc_data = data_q;
    assign spi.cs_sel   = cs_q;
    assign state_o      = state;
endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Scoreboard bench for adc_cfg_sequencer: expected SPI words are
// queued by the stimulus and popped by a monitor on every start.
module tb_adc_cfg_sequencer;
    localparam logic [31:0] W_TEST = 32'h000D0C0C;
    localparam logic [31:0] W_WORK = 32'h000D0000;
    localparam logic [31:0] W_UPD  = 32'h00FF0101;
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_WIDL = 4'd4;
    localparam logic [3:0] ST_GAP  = 4'd5;
    localparam logic [3:0] ST_ALGN = 4'd6;
    localparam logic [3:0] ST_DONE = 4'd7;
    localparam logic [3:0] ST_ERR  = 4'd8;

    typedef struct {
        logic [31:0] cs;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] data_aligned = 2'b00;
    logic       recfg = 1'b0;
    logic       test_cfg_done, spi_done, cfg_error;
    logic [3:0] retry_cnt, state_o;

    int   errors = 0;
    int   checks = 0;
    int   n_starts = 0;
    int   cyc = 0;
    bit   ack_en = 1'b1;
    bit   prev_start = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    adc_cfg_sequencer_if #(.DATA_W(32), .CS_W(1)) bus ();

    adc_cfg_sequencer #(
        .N_CH(2), .DATA_W(32), .DLY_W(24),
        .DELAY_CYC(24'd8), .ALIGN_TO(24'd32),
        .MAX_RETRY(3), .ACK_TO(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (bus),
        .data_aligned (data_aligned),
        .recfg        (recfg),
        .test_cfg_done(test_cfg_done),
        .spi_done     (spi_done),
        .cfg_error    (cfg_error),
        .retry_cnt    (retry_cnt),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] mode);
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back('{cs: c, data: mode});
            exp_q.push_back('{cs: c, data: W_UPD});
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int max,
                              input string nm);
        int n = 0;
        while (state_o !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(state_o), 32'(s));
    endtask

    task automatic wait_start(input int max, output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.start && n < max);
        check("start_seen", 32'(bus.start), 32'd1);
        c = cyc;
    endtask

    task automatic pulse_recfg();
        recfg = 1'b1;
        @(negedge clk);
        recfg = 1'b0;
    endtask

    // SPI master model: busy for 20 cycles after each start when acking.
    initial begin
        bus.spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.start && ack_en) begin
                bus.spi_busy = 1'b1;
                repeat (20) @(negedge clk);
                bus.spi_busy = 1'b0;
            end
        end
    end

    // Monitor: every start pops one expected word.
    always @(negedge clk) begin
        if (!reset && bus.start) begin
            n_starts++;
            check("no_back_to_back", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: cs %0d data %h, expected none",
                         bus.cs_sel, bus.adc_data);
            end else begin
                e = exp_q.pop_front();
                check("spi_word", bus.adc_data, e.data);
                check("spi_cs", 32'(bus.cs_sel), e.cs);
            end
        end
        prev_start = bus.start;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int c0, c1, s0;
        #1;
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_data", bus.adc_data, 32'd0);
        check("rst_flags", {test_cfg_done, spi_done, cfg_error, retry_cnt}, 32'd0);
        repeat (3) @(negedge clk);

        // Normal run: test phase, alignment after 5 cycles, work phase.
        push_seq(W_TEST);
        reset = 1'b0;
        wait_state(ST_ALGN, 2000, "reach_align");
        check("tcd_set", 32'(test_cfg_done), 32'd1);
        check("test_starts", 32'(n_starts), 32'd4);
        check("test_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        push_seq(W_WORK);
        data_aligned = 2'b11;
        wait_state(ST_DONE, 2000, "reach_done");
        check("done_flag", 32'(spi_done), 32'd1);
        check("done_no_err", 32'(cfg_error), 32'd0);
        check("done_tcd", 32'(test_cfg_done), 32'd1);
        check("done_retry", 32'(retry_cnt), 32'd0);
        check("work_q_empty", 32'(exp_q.size()), 32'd0);

        // recfg in DONE replays; recfg in GAP is ignored.
        @(negedge clk);
        push_seq(W_TEST);
        push_seq(W_WORK);
        pulse_recfg();
        check("recfg_idle", 32'(state_o), 32'(ST_IDLE));
        check("recfg_clear", {test_cfg_done, spi_done}, 32'd0);
        wait_state(ST_GAP, 500, "reach_gap");
        pulse_recfg();
        check("gap_recfg_ign", 32'(state_o), 32'(ST_GAP));
        wait_state(ST_DONE, 3000, "replay_done");
        check("replay_flag", 32'(spi_done), 32'd1);
        check("replay_q_empty", 32'(exp_q.size()), 32'd0);

        // Alignment never completes: three retries then ERROR.
        data_aligned = 2'b01;
        @(negedge clk);
        s0 = n_starts;
        for (int r = 0; r < 4; r++) push_seq(W_TEST);
        pulse_recfg();
        wait_state(ST_ERR, 4000, "reach_error");
        check("err_flag", 32'(cfg_error), 32'd1);
        check("err_retry", 32'(retry_cnt), 32'd3);
        check("err_tcd", 32'(test_cfg_done), 32'd0);
        check("err_no_done", 32'(spi_done), 32'd0);
        check("err_starts", 32'(n_starts - s0), 32'd16);
        check("err_q_empty", 32'(exp_q.size()), 32'd0);

        // SPI master never acks: ACK_TO fallback, 26 cycles start-to-start.
        ack_en = 1'b0;
        data_aligned = 2'b11;
        @(negedge clk);
        push_seq(W_TEST);
        push_seq(W_WORK);
        pulse_recfg();
        check("err_cleared", {cfg_error, retry_cnt}, 32'd0);
        wait_start(200, c0);
        wait_start(200, c1);
        check("noack_interval", 32'(c1 - c0), 32'd26);
        wait_state(ST_DONE, 3000, "noack_done");
        check("noack_flag", 32'(spi_done), 32'd1);
        check("noack_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-WAIT_IDLE, then clean restart once busy drops.
        ack_en = 1'b1;
        @(negedge clk);
        push_seq(W_TEST);
        pulse_recfg();
        wait_state(ST_WIDL, 500, "reach_widle");
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
        check("mid_rst_start", 32'(bus.start), 32'd0);
        check("mid_rst_out", {bus.adc_data[27:0], bus.cs_sel, test_cfg_done,
                              spi_done, cfg_error}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("busy_active", 32'(bus.spi_busy), 32'd1);
        check("idle_while_busy", 32'(state_o), 32'(ST_IDLE));
        push_seq(W_TEST);
        push_seq(W_WORK);
        wait_state(ST_DONE, 3000, "restart_done");
        check("restart_flag", 32'(spi_done), 32'd1);
        check("restart_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
